// File: rtl/shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding,
// default operand width and the iteration counter sizing rule.
package shift_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter has to reach WIDTH-1; keep at least one bit for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_add_nbit.sv
// WIDTH-bit adder built from 4-bit carry-lookahead blocks rippled on carry.
// Pure combinational; used as the per-iteration partial-sum stage.
module add_nbit #(
  parameter int WIDTH = shift_add_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NBLK = WIDTH / 4;

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;
  logic       c_blk;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    g     = '0;
    p     = '0;
    c     = '0;
    sum   = '0;
    c_blk = cin;
    for (int k = 0; k < NBLK; k++) begin
      g = a[4*k +: 4] & b[4*k +: 4];
      p = a[4*k +: 4] ^ b[4*k +: 4];
      c[0] = c_blk;
      c[1] = g[0] | (p[0] & c_blk);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_blk);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c_blk);
      c_blk = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_blk);
      sum[4*k +: 4] = p ^ c;
    end
    cout = c_blk;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one add/shift per cycle for
// WIDTH cycles, then a one-cycle done pulse with the registered product.
module shift_add_multiplier
  import shift_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] shifted;
  logic               last;
  logic               accept;

  assign add_b   = acc_lo[0] ? mcand : '0;
  // {cout, sum, acc_lo} shifted right by one drops the consumed multiplier bit.
  assign shifted = {add_cout, add_sum, acc_lo[WIDTH-1:1]};
  assign last    = (count == CW'(WIDTH - 1));
  assign accept  = start && (state != ST_RUN);

  add_nbit #(.WIDTH(WIDTH)) u_add (
    .a    (acc_hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the datapath is reset too, so an aborted operation leaves no stale
  // operands or partial sums behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      count   <= '0;
      product <= '0;
    end else if (accept) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
      count  <= '0;
    end else if (state == ST_RUN) begin
      {acc_hi, acc_lo} <= shifted;
      count            <= count + 1'b1;
      if (last) product <= shifted;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH=4 and WIDTH=8).
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int checks   = 0;
  int failures = 0;

  shift_add_multiplier #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .busy    (busy8),
    .done    (done8),
    .product (product8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands for the accept edge, then scramble them afterwards.
  task automatic accept(input logic [3:0] x, input logic [3:0] y);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 4'hA;
    b = 4'h5;
  endtask

  // Starts in cycle 1 after accept; ends inside the DONE cycle (cycle 5).
  task automatic follow(input logic [7:0] exp, input string tag, input bit poke);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("%s_busy_c%0d", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s_nodone_c%0d", tag, i), 32'(done), 32'd0);
      if (poke && i == 2) begin
        start = 1'b1;
        a = 4'd7;
        b = 4'd7;
      end
      if (poke && i == 4) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_product"}, 32'(product), 32'(exp));
  endtask

  task automatic after_done(input logic [7:0] exp, input string tag);
    @(posedge clk);
    #1;
    check({tag, "_pulse_end"}, 32'(done), 32'd0);
    check({tag, "_no_rerun"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(product), 32'(exp));
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;

    // Reset state, released mid-cycle, then idle with start low.
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_product", 32'(product), 32'd0);

    // Basic multiplies from IDLE.
    accept(4'd15, 4'd15); follow(8'hE1, "m15x15", 1'b0); after_done(8'hE1, "m15x15");
    accept(4'd13, 4'd11); follow(8'h8F, "m13x11", 1'b0); after_done(8'h8F, "m13x11");
    accept(4'd0,  4'd9);  follow(8'h00, "m0x9",   1'b0); after_done(8'h00, "m0x9");
    accept(4'd1,  4'd15); follow(8'h0F, "m1x15",  1'b0); after_done(8'h0F, "m1x15");

    // start during RUN is ignored; only one result comes out.
    accept(4'd3, 4'd5); follow(8'h0F, "ignore", 1'b1); after_done(8'h0F, "ignore");
    repeat (3) begin
      @(posedge clk);
      #1;
      check("ignore_quiet_done", 32'(done), 32'd0);
    end

    // Back-to-back: second start issued in the DONE cycle.
    accept(4'd6, 4'd7); follow(8'd42, "b2b_first", 1'b0);
    accept(4'd9, 4'd9); follow(8'd81, "b2b_second", 1'b0); after_done(8'd81, "b2b_second");

    // Asynchronous reset in cycle 2 of an operation.
    accept(4'd15, 4'd15);
    check("abort_busy_c1", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort_nodone_%0d", i), 32'(done), 32'd0);
      check($sformatf("abort_nobusy_%0d", i), 32'(busy), 32'd0);
    end
    accept(4'd2, 4'd3); follow(8'd6, "post_abort", 1'b0); after_done(8'd6, "post_abort");

    // WIDTH=8 instance: 255*255, done in cycle 9.
    a8 = 8'd255;
    b8 = 8'd255;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'h00;
    b8 = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("w8_busy_c%0d", i), 32'(busy8), 32'd1);
      check($sformatf("w8_nodone_c%0d", i), 32'(done8), 32'd0);
      @(posedge clk);
      #1;
    end
    check("w8_done", 32'(done8), 32'd1);
    check("w8_product", 32'(product8), 32'hFE01);
    @(posedge clk);
    #1;
    check("w8_pulse_end", 32'(done8), 32'd0);
    check("w8_hold", 32'(product8), 32'hFE01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
